msx_slot_io_initiator: RTL and testbench

//  Synthesizable MSX slot bus master that issues Z80-style I/O read/write cycles
//  (IORQ_n/RD_n/WR_n/A[7:0]/D[7:0]) toward a slot-side I/O responder, e.g. the VDP cartridge.

---
 rtl/msx_slot_io_initiator_pkg.sv | 38 +++
 rtl/msx_slot_io_initiator_if.sv | 38 +++
 rtl/msx_slot_io_initiator_sync.sv | 27 ++
 rtl/msx_slot_io_initiator.sv | 160 ++++++++++++++++
 tb/tb_msx_slot_io_initiator.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msx_slot_io_initiator_pkg.sv
// Shared types and constants for the MSX slot I/O initiator and its responder/bench.
package msx_slot_io_initiator_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TCNT_W = 4;
    localparam int unsigned WCNT_W = 8;

    // Bus cycle phases of one Z80 I/O cycle
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_HOLD = 3'd5
    } bus_state_e;

    // Active levels of the slot control lines
    localparam logic IORQ_ACTIVE = 1'b0;
    localparam logic RD_ACTIVE   = 1'b0;
    localparam logic WR_ACTIVE   = 1'b0;
    localparam logic WAIT_ACTIVE = 1'b1;
    localparam logic INT_ACTIVE  = 1'b1;

    // Request payload as presented on the request handshake
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } io_req_t;

    // Pin level for a strobe given whether it is asserted and its active level
    function automatic logic strobe_level(input logic asserted, input logic active);
        return asserted ? active : ~active;
    endfunction

endpackage

// File: rtl/msx_slot_io_initiator_if.sv
// Request/response handshake plus slot-side pins of the I/O initiator.
interface msx_slot_io_initiator_if;
    import msx_slot_io_initiator_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_ack;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_timeout;
    logic              int_req;
    logic [ADDR_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_d_out;
    logic              bus_d_oe;
    logic [DATA_W-1:0] bus_d_in;
    logic              bus_iorq_n;
    logic              bus_rd_n;
    logic              bus_wr_n;
    logic              bus_wait;
    logic              bus_int;

    // Initiator view
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_d_in, bus_wait, bus_int,
        output req_ready, resp_ack, resp_rdata, resp_timeout, int_req,
               bus_a, bus_d_out, bus_d_oe, bus_iorq_n, bus_rd_n, bus_wr_n
    );

    // Requester / target view
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_d_in, bus_wait, bus_int,
        input  req_ready, resp_ack, resp_rdata, resp_timeout, int_req,
               bus_a, bus_d_out, bus_d_oe, bus_iorq_n, bus_rd_n, bus_wr_n
    );

endinterface

// File: rtl/msx_slot_io_initiator_sync.sv
// Parameterised-width two-flop synchroniser with synchronous active-high reset.
module msx_slot_io_initiator_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/msx_slot_io_initiator.sv
// MSX slot bus master issuing Z80-style IN/OUT cycles with WAIT support and INT sync.
module msx_slot_io_initiator
    import msx_slot_io_initiator_pkg::*;
#(
    parameter int unsigned TSTATE_CLKS = 7,
    parameter int unsigned WAIT_LIMIT  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    msx_slot_io_initiator_if.master bus_if
);

    localparam logic [TCNT_W-1:0] T_LOAD  = TCNT_W'(TSTATE_CLKS - 1);
    localparam logic [WCNT_W-1:0] W_LIMIT = WCNT_W'(WAIT_LIMIT);

    bus_state_e        state_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              write_q;
    logic              ready_q;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              timeout_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] dout_q;
    logic              doe_q;
    logic              iorq_n_q;
    logic              rd_n_q;
    logic              wr_n_q;

    io_req_t           req_in;
    logic [1:0]        async_in;
    logic [1:0]        synced;
    logic              wait_s;
    logic              t_last;

    assign req_in   = '{write: bus_if.req_write, addr: bus_if.req_addr, wdata: bus_if.req_wdata};
    assign async_in = {bus_if.bus_int, bus_if.bus_wait};
    assign wait_s   = (synced[0] == WAIT_ACTIVE);
    assign t_last   = (tcnt_q == '0);

    msx_slot_io_initiator_sync #(
        .WIDTH (2)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (async_in),
        .q_o   (synced)
    );

    // Cycle sequencer: T-state timer, wait counter and all registered bus/response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tcnt_q    <= '0;
            wcnt_q    <= '0;
            write_q   <= 1'b0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            a_q       <= '0;
            dout_q    <= '0;
            doe_q     <= 1'b0;
            iorq_n_q  <= strobe_level(1'b0, IORQ_ACTIVE);
            rd_n_q    <= strobe_level(1'b0, RD_ACTIVE);
            wr_n_q    <= strobe_level(1'b0, WR_ACTIVE);
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.req_valid && ready_q) begin
                        write_q   <= req_in.write;
                        a_q       <= req_in.addr;
                        if (req_in.write) begin
                            dout_q <= req_in.wdata;
                        end
                        doe_q     <= req_in.write;
                        timeout_q <= 1'b0;
                        wcnt_q    <= '0;
                        tcnt_q    <= T_LOAD;
                        ready_q   <= 1'b0;
                        state_q   <= ST_T1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_T1: begin
                    if (t_last) begin
                        tcnt_q   <= T_LOAD;
                        iorq_n_q <= strobe_level(1'b1, IORQ_ACTIVE);
                        rd_n_q   <= strobe_level(!write_q, RD_ACTIVE);
                        wr_n_q   <= strobe_level(write_q, WR_ACTIVE);
                        state_q  <= ST_T2;
                    end else begin
                        tcnt_q <= tcnt_q - TCNT_W'(1);
                    end
                end
                ST_T2: begin
                    if (t_last) begin
                        tcnt_q  <= T_LOAD;
                        state_q <= ST_TW;
                    end else begin
                        tcnt_q <= tcnt_q - TCNT_W'(1);
                    end
                end
                ST_TW: begin
                    if (t_last) begin
                        tcnt_q <= T_LOAD;
                        if (wait_s && (wcnt_q < W_LIMIT)) begin
                            wcnt_q <= wcnt_q + WCNT_W'(1);
                        end else begin
                            if (wait_s) begin
                                timeout_q <= 1'b1;
                            end
                            state_q <= ST_T3;
                        end
                    end else begin
                        tcnt_q <= tcnt_q - TCNT_W'(1);
                    end
                end
                ST_T3: begin
                    if (t_last) begin
                        if (!write_q) begin
                            rdata_q <= bus_if.bus_d_in;
                        end
                        iorq_n_q <= strobe_level(1'b0, IORQ_ACTIVE);
                        rd_n_q   <= strobe_level(1'b0, RD_ACTIVE);
                        wr_n_q   <= strobe_level(1'b0, WR_ACTIVE);
                        state_q  <= ST_HOLD;
                    end else begin
                        tcnt_q <= tcnt_q - TCNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    doe_q   <= 1'b0;
                    ack_q   <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_if.req_ready    = ready_q;
    assign bus_if.resp_ack     = ack_q;
    assign bus_if.resp_rdata   = rdata_q;
    assign bus_if.resp_timeout = timeout_q;
    assign bus_if.int_req      = (synced[1] == INT_ACTIVE);
    assign bus_if.bus_a        = a_q;
    assign bus_if.bus_d_out    = dout_q;
    assign bus_if.bus_d_oe     = doe_q;
    assign bus_if.bus_iorq_n   = iorq_n_q;
    assign bus_if.bus_rd_n     = rd_n_q;
    assign bus_if.bus_wr_n     = wr_n_q;

endmodule

// File: tb/tb_msx_slot_io_initiator.sv
// Self-checking bench: directed and random I/O cycles against a timing/behaviour model.
module tb_msx_slot_io_initiator;

    localparam int T      = 7;
    localparam int LIM0   = 255;
    localparam int LIM1   = 3;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic use_t = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_rdata [2];

    msx_slot_io_initiator_if if0 ();
    msx_slot_io_initiator_if ift ();

    msx_slot_io_initiator #(.TSTATE_CLKS(T), .WAIT_LIMIT(LIM0)) dut0 (
        .clk    (clk),
        .reset  (reset),
        .bus_if (if0)
    );

    msx_slot_io_initiator #(.TSTATE_CLKS(T), .WAIT_LIMIT(LIM1)) dut_t (
        .clk    (clk),
        .reset  (reset),
        .bus_if (ift)
    );

    // Second instance sees exactly the same stimulus
    assign ift.req_valid = if0.req_valid;
    assign ift.req_write = if0.req_write;
    assign ift.req_addr  = if0.req_addr;
    assign ift.req_wdata = if0.req_wdata;
    assign ift.bus_d_in  = if0.bus_d_in;
    assign ift.bus_wait  = if0.bus_wait;
    assign ift.bus_int   = if0.bus_int;

    wire       s_ready = use_t ? ift.req_ready    : if0.req_ready;
    wire       s_ack   = use_t ? ift.resp_ack     : if0.resp_ack;
    wire [7:0] s_rdata = use_t ? ift.resp_rdata   : if0.resp_rdata;
    wire       s_tout  = use_t ? ift.resp_timeout : if0.resp_timeout;
    wire [7:0] s_a     = use_t ? ift.bus_a        : if0.bus_a;
    wire [7:0] s_dout  = use_t ? ift.bus_d_out    : if0.bus_d_out;
    wire       s_doe   = use_t ? ift.bus_d_oe     : if0.bus_d_oe;
    wire       s_iorq  = use_t ? ift.bus_iorq_n   : if0.bus_iorq_n;
    wire       s_rd    = use_t ? ift.bus_rd_n     : if0.bus_rd_n;
    wire       s_wr    = use_t ? ift.bus_wr_n     : if0.bus_wr_n;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Extra TW states: each TW ends every T clks starting 2T after the strobe falls; the
    // synchronised WAIT seen there reflects the pin 2 clks earlier; pin held h clks after the fall.
    function automatic int n_extra(input int h, input int limit);
        int n = 0;
        if (h > 0) begin
            while (n < limit && (2 * T + n * T) <= h + 1) n++;
        end
        return n;
    endfunction

    function automatic logic timed_out(input int h, input int limit);
        return (h > 0) && (n_extra(h, limit) == limit) && ((2 * T + limit * T) <= h + 1);
    endfunction

    // Issue one request on the edge after a negedge and observe the selected DUT until ack
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdv, input int h,
                           output int lat, output int iorq_lo, output int rd_lo, output int wr_lo,
                           output int doe_hi, output logic [7:0] rdata, output logic tout,
                           output int bad_bus);
        int c = 0;
        int fall = -1;
        int k = 0;
        logic done = 1'b0;
        lat = -1; iorq_lo = 0; rd_lo = 0; wr_lo = 0; doe_hi = 0; bad_bus = 0;
        rdata = 8'h00; tout = 1'b0;
        if0.req_valid = 1'b1;
        if0.req_write = wr;
        if0.req_addr  = addr;
        if0.req_wdata = wdata;
        if0.bus_wait  = (h > 0);
        while (!done && c < BUDGET) begin
            @(negedge clk);
            c++;
            if0.req_valid = 1'b0;
            if (s_iorq === 1'b0) begin
                iorq_lo++;
                if (fall < 0) fall = c;
                if (s_a !== addr) bad_bus++;
            end
            if (s_rd === 1'b0) rd_lo++;
            if (s_wr === 1'b0) wr_lo++;
            if (s_doe === 1'b1) begin
                doe_hi++;
                if (s_dout !== wdata) bad_bus++;
            end
            if0.bus_d_in = (s_rd === 1'b0) ? rdv : ~rdv;
            if (fall >= 0 && c == fall + h - 1) if0.bus_wait = 1'b0;
            if (s_ack === 1'b1) begin
                done  = 1'b1;
                lat   = c;
                rdata = s_rdata;
                tout  = s_tout;
            end
        end
        if0.bus_wait = 1'b0;
        while (!(if0.req_ready === 1'b1 && ift.req_ready === 1'b1) && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic txn_check(input string tag, input int sel, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rdv, input int h);
        int limit, n, lat, iorq_lo, rd_lo, wr_lo, doe_hi, bad_bus;
        logic [7:0] rdata;
        logic tout;
        use_t = (sel != 0);
        limit = (sel != 0) ? LIM1 : LIM0;
        n = n_extra(h, limit);
        chk({tag, "_ready"}, 32'(s_ready), 32'(1));
        run_txn(wr, addr, wdata, rdv, h, lat, iorq_lo, rd_lo, wr_lo, doe_hi, rdata, tout, bad_bus);
        if (!wr) exp_rdata[sel] = rdv;
        chk({tag, "_lat"},    32'(lat),     32'((4 + n) * T + 2));
        chk({tag, "_iorq"},   32'(iorq_lo), 32'((3 + n) * T));
        chk({tag, "_rd_lo"},  32'(rd_lo),   wr ? 32'(0) : 32'((3 + n) * T));
        chk({tag, "_wr_lo"},  32'(wr_lo),   wr ? 32'((3 + n) * T) : 32'(0));
        chk({tag, "_doe"},    32'(doe_hi),  wr ? 32'((4 + n) * T + 1) : 32'(0));
        chk({tag, "_rdata"},  32'(rdata),   32'(exp_rdata[sel]));
        chk({tag, "_tout"},   32'(tout),    32'(timed_out(h, limit)));
        chk({tag, "_busval"}, 32'(bad_bus), 32'(0));
    endtask

    initial begin
        int c;
        int acks;
        int idx;
        int wr_tot;
        logic pending;
        int ack_c [3];
        logic [7:0] bb_addr [3];
        logic [7:0] bb_data [3];

        if0.req_valid = 1'b0;
        if0.req_write = 1'b0;
        if0.req_addr  = 8'h00;
        if0.req_wdata = 8'h00;
        if0.bus_d_in  = 8'h00;
        if0.bus_wait  = 1'b0;
        if0.bus_int   = 1'b0;
        exp_rdata[0]  = 8'h00;
        exp_rdata[1]  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(if0.req_ready),    32'(0));
        chk("rst_ack",   32'(if0.resp_ack),     32'(0));
        chk("rst_rdata", 32'(if0.resp_rdata),   32'(0));
        chk("rst_tout",  32'(if0.resp_timeout), 32'(0));
        chk("rst_int",   32'(if0.int_req),      32'(0));
        chk("rst_a",     32'(if0.bus_a),        32'(0));
        chk("rst_dout",  32'(if0.bus_d_out),    32'(0));
        chk("rst_doe",   32'(if0.bus_d_oe),     32'(0));
        chk("rst_strb",  32'({if0.bus_iorq_n, if0.bus_rd_n, if0.bus_wr_n}), 32'(3'b111));
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 32'(if0.req_ready), 32'(1));

        // Directed: plain write, plain read, read stretched by WAIT
        txn_check("wr98", 0, 1'b1, 8'h98, 8'h5A, 8'h00, 0);
        txn_check("rd99", 0, 1'b0, 8'h99, 8'h00, 8'hC3, 0);
        txn_check("rdwait", 0, 1'b0, 8'h99, 8'h00, 8'h3C, 30);
        txn_check("wrwait", 0, 1'b1, 8'h10, 8'hE7, 8'h00, 17);

        // Random traffic
        for (int i = 0; i < 10; i++) begin
            logic w;
            logic [7:0] a, d, r;
            int h;
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            d = 8'($urandom);
            r = 8'($urandom);
            h = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 45));
            txn_check($sformatf("rnd%0d", i), 0, w, a, d, r, h);
        end

        // Timeout on the WAIT_LIMIT=3 instance, then timeout cleared by the next accept
        txn_check("tmo", 1, 1'b0, 8'h77, 8'h00, 8'h96, 40);
        txn_check("tmo_clr", 1, 1'b0, 8'h78, 8'h00, 8'h69, 0);

        // Reset on the 3rd clk of T2 of a write
        use_t = 1'b0;
        if0.req_valid = 1'b1;
        if0.req_write = 1'b1;
        if0.req_addr  = 8'h42;
        if0.req_wdata = 8'hA5;
        for (int i = 1; i <= T + 3; i++) begin
            @(negedge clk);
            if0.req_valid = 1'b0;
        end
        chk("mid_iorq_low", 32'(if0.bus_iorq_n), 32'(0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        chk("abort_strb", 32'({if0.bus_iorq_n, if0.bus_rd_n, if0.bus_wr_n}), 32'(3'b111));
        chk("abort_doe",  32'(if0.bus_d_oe), 32'(0));
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if0.resp_ack === 1'b1) acks++;
        end
        chk("abort_noack", 32'(acks), 32'(0));
        txn_check("post_rst", 0, 1'b1, 8'h43, 8'h1E, 8'h00, 0);

        // Back-to-back writes with req_valid held high
        use_t = 1'b0;
        bb_addr[0] = 8'h20; bb_addr[1] = 8'h21; bb_addr[2] = 8'h22;
        bb_data[0] = 8'($urandom); bb_data[1] = 8'($urandom); bb_data[2] = 8'($urandom);
        idx = 0; acks = 0; c = 0; wr_tot = 0;
        if0.req_write = 1'b1;
        if0.req_addr  = bb_addr[0];
        if0.req_wdata = bb_data[0];
        if0.req_valid = 1'b1;
        pending = (s_ready === 1'b1);
        while (acks < 3 && c < BUDGET) begin
            @(negedge clk);
            c++;
            if (pending) begin
                idx++;
                if (idx < 3) begin
                    if0.req_addr  = bb_addr[idx];
                    if0.req_wdata = bb_data[idx];
                end else begin
                    if0.req_valid = 1'b0;
                end
            end
            pending = (if0.req_valid === 1'b1) && (s_ready === 1'b1);
            if (s_wr === 1'b0) wr_tot++;
            if (s_ack === 1'b1) begin
                ack_c[acks] = c;
                acks++;
            end
        end
        if0.req_valid = 1'b0;
        chk("b2b_acks", 32'(acks), 32'(3));
        chk("b2b_first", 32'(ack_c[0]), 32'(4 * T + 2));
        chk("b2b_sp1", 32'(ack_c[1] - ack_c[0]), 32'(4 * T + 2));
        chk("b2b_sp2", 32'(ack_c[2] - ack_c[1]), 32'(4 * T + 2));
        chk("b2b_wrlo", 32'(wr_tot), 32'(3 * 3 * T));
        chk("b2b_a_hold", 32'(if0.bus_a), 32'(bb_addr[2]));
        chk("b2b_rdata", 32'(if0.resp_rdata), 32'(exp_rdata[0]));

        // INT synchronisation latency
        @(negedge clk);
        if0.bus_int = 1'b1;
        @(negedge clk);
        chk("int_rise_1", 32'(if0.int_req), 32'(0));
        @(negedge clk);
        chk("int_rise_2", 32'(if0.int_req), 32'(1));
        chk("int_rise_t", 32'(ift.int_req), 32'(1));
        if0.bus_int = 1'b0;
        @(negedge clk);
        chk("int_fall_1", 32'(if0.int_req), 32'(1));
        @(negedge clk);
        chk("int_fall_2", 32'(if0.int_req), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
